// File: rtl/vxe_ctrl_mem_bridge_pkg.sv
// Shared constants and payload types for the VxE control-unit memory bridge.
package vxe_ctrl_mem_bridge_pkg;

  // Request word layout: {txnid, addr}
  localparam int unsigned TXNID_MSB = 43;
  localparam int unsigned ADDR_MSB  = 36;
  localparam int unsigned TXNID_W   = TXNID_MSB - ADDR_MSB;
  localparam int unsigned ADDR_W    = ADDR_MSB + 1;

  // FIFO and bus widths
  localparam int unsigned RQA_W   = 44;
  localparam int unsigned RSS_W   = 9;
  localparam int unsigned RSD_W   = 64;
  localparam int unsigned MADDR_W = ADDR_W + 3;

  // Response status codes
  typedef enum logic [1:0] {
    RS_OK   = 2'b00,
    RS_SERR = 2'b01,
    RS_DERR = 2'b10,
    RS_TMO  = 2'b11
  } rs_status_e;

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic [ADDR_W-1:0]  addr;
  } rqa_t;

  typedef struct packed {
    logic [1:0]         status;
    logic [TXNID_W-1:0] txnid;
  } rss_t;

  // 64-bit word address to byte address
  function automatic logic [MADDR_W-1:0] word_to_byte(input logic [ADDR_W-1:0] addr);
    return {addr, 3'b000};
  endfunction

endpackage

// File: rtl/vxe_fifo.sv
// Power-of-two synchronous FIFO, ready/valid on both sides, first-word fall-through.
module vxe_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_POW2;
  localparam int unsigned PTR_W = DEPTH_POW2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Wrap bit differs with equal index bits: full; identical pointers: empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);

  assign in_rdy   = ~full;
  assign out_vld  = ~empty;
  assign push     = in_vld & ~full;
  assign pop      = out_rdy & ~empty;
  assign out_data = mem[rd_ptr[DEPTH_POW2-1:0]];

  // Storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_POW2-1:0]] <= in_data;
  end

  // Pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/vxe_ctrl_mem_bridge.sv
// Bridge between the VxE request FIFO, the in-order memory read bus and the
// response status/data FIFOs, with an age timer that times out stuck reads.
module vxe_ctrl_mem_bridge
  import vxe_ctrl_mem_bridge_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rqa_vld,
  input  logic [RQA_W-1:0]   i_rqa,
  output logic               o_rqa_rd,
  output logic               o_mrq_vld,
  output logic [MADDR_W-1:0] o_mrq_addr,
  input  logic               i_mrq_rdy,
  input  logic               i_mrs_vld,
  input  logic [RSD_W-1:0]   i_mrs_data,
  input  logic [1:0]         i_mrs_err,
  output logic               o_mrs_rdy,
  output logic [RSS_W-1:0]   o_rss,
  output logic               o_rss_wr,
  input  logic               i_rss_rdy,
  output logic [RSD_W-1:0]   o_rsd,
  output logic               o_rsd_wr,
  input  logic               i_rsd_rdy,
  output logic               o_idle
);

  localparam int unsigned DEPTH_POW2 = $clog2(MAX_OUT);
  localparam int unsigned CNT_W      = DEPTH_POW2 + 1;
  localparam int unsigned OWED_W     = CNT_W + 1;
  localparam int unsigned AGE_W      = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
  localparam bit   TMO_EN  = (TIMEOUT != 0);

  rqa_t               rqa;
  logic               mrq_vld_q;
  logic [ADDR_W-1:0]  mrq_addr_q;

  logic               trk_push;
  logic               trk_pop;
  logic               trk_in_rdy;
  logic               trk_out_vld;
  logic               trk_full;
  logic               trk_empty;
  logic [TXNID_W-1:0] trk_head;
  logic [CNT_W-1:0]   trk_count;
  logic [CNT_W-1:0]   drop_cnt;
  logic [OWED_W-1:0]  owed;
  logic [AGE_W-1:0]   age;

  logic               fifo_ok;
  logic               mrs_rdy;
  logic               rsp_hs;
  logic               tmo_fire;
  logic               drop_dec;
  rss_t               rss;
  logic [RSD_W-1:0]   rsd;

  assign rqa       = i_rqa;
  assign trk_full  = ~trk_in_rdy;
  assign trk_empty = ~trk_out_vld;
  assign owed      = OWED_W'(trk_count) + OWED_W'(drop_cnt);
  assign fifo_ok   = i_rss_rdy & i_rsd_rdy;

  // Pop a request when the tracker and the bus budget have room and the request register is free
  assign o_rqa_rd = i_rqa_vld & trk_full == 1'b0 & (owed < OWED_W'(MAX_OUT)) &
                    (~mrq_vld_q | i_mrq_rdy);
  assign trk_push = o_rqa_rd;
  assign trk_pop  = rsp_hs | tmo_fire;

  // In-order txnid tracker
  vxe_fifo #(
    .DATA_WIDTH (TXNID_W),
    .DEPTH_POW2 (DEPTH_POW2)
  ) u_trk (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (trk_push),
    .in_rdy   (trk_in_rdy),
    .in_data  (rqa.txnid),
    .out_vld  (trk_out_vld),
    .out_rdy  (trk_pop),
    .out_data (trk_head)
  );

  // Bus request register, held until the bus accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mrq_vld_q  <= 1'b0;
      mrq_addr_q <= '0;
    end else if (o_rqa_rd) begin
      mrq_vld_q  <= 1'b1;
      mrq_addr_q <= rqa.addr;
    end else if (i_mrq_rdy) begin
      mrq_vld_q  <= 1'b0;
    end
  end

  // Response routing: discard late replies, pass normal replies, or synthesise a timeout
  always_comb begin
    mrs_rdy  = 1'b0;
    rsp_hs   = 1'b0;
    drop_dec = 1'b0;
    tmo_fire = 1'b0;
    rss      = '0;
    rsd      = '0;
    if (drop_cnt != '0) begin
      mrs_rdy  = 1'b1;
      drop_dec = i_mrs_vld;
    end else begin
      mrs_rdy = fifo_ok & ~trk_empty;
      rsp_hs  = i_mrs_vld & mrs_rdy;
    end
    tmo_fire = TMO_EN && (age == AGE_MAX) && !rsp_hs && fifo_ok && !trk_empty;
    if (rsp_hs) begin
      rss.status = i_mrs_err;
      rss.txnid  = trk_head;
      rsd        = i_mrs_data;
    end else if (tmo_fire) begin
      rss.status = RS_TMO;
      rss.txnid  = trk_head;
    end
  end

  // Tracker occupancy, late-reply drop count and head age
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_count <= '0;
      drop_cnt  <= '0;
      age       <= '0;
    end else begin
      if (trk_push && !trk_pop)      trk_count <= trk_count + CNT_W'(1);
      else if (trk_pop && !trk_push) trk_count <= trk_count - CNT_W'(1);

      if (tmo_fire && !drop_dec)      drop_cnt <= drop_cnt + CNT_W'(1);
      else if (drop_dec && !tmo_fire) drop_cnt <= drop_cnt - CNT_W'(1);

      if (trk_pop || trk_empty) age <= '0;
      else if (age != AGE_MAX)  age <= age + AGE_W'(1);
    end
  end

  assign o_mrq_vld  = mrq_vld_q;
  assign o_mrq_addr = word_to_byte(mrq_addr_q);
  assign o_mrs_rdy  = mrs_rdy;
  assign o_rss      = rss;
  assign o_rsd      = rsd;
  assign o_rss_wr   = trk_pop;
  assign o_rsd_wr   = trk_pop;
  assign o_idle     = trk_empty & (drop_cnt == '0) & ~mrq_vld_q;

endmodule

// File: tb/tb_vxe_ctrl_mem_bridge.sv
// Directed self-checking bench for vxe_ctrl_mem_bridge (MAX_OUT = 4, TIMEOUT = 8).
module tb_vxe_ctrl_mem_bridge;

  logic        clk;
  logic        rst;
  logic        i_rqa_vld;
  logic [43:0] i_rqa;
  logic        o_rqa_rd;
  logic        o_mrq_vld;
  logic [39:0] o_mrq_addr;
  logic        i_mrq_rdy;
  logic        i_mrs_vld;
  logic [63:0] i_mrs_data;
  logic [1:0]  i_mrs_err;
  logic        o_mrs_rdy;
  logic [8:0]  o_rss;
  logic        o_rss_wr;
  logic        i_rss_rdy;
  logic [63:0] o_rsd;
  logic        o_rsd_wr;
  logic        i_rsd_rdy;
  logic        o_idle;

  int n_checks = 0;
  int n_errors = 0;

  // Request FIFO model
  logic [43:0] rq_mem [64];
  int          rq_head = 0;
  int          rq_tail = 0;
  int          cyc = 0;
  int          last_pop_cyc = 0;

  // Bus and response-FIFO logs
  logic [39:0] iss_addr [128];
  logic [8:0]  rss_log  [128];
  logic [63:0] rsd_log  [128];
  int          rss_cyc  [128];
  int          iss_cnt = 0;
  int          ws_cnt  = 0;
  int          wd_cnt  = 0;

  vxe_ctrl_mem_bridge #(.MAX_OUT(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rqa_vld  (i_rqa_vld),
    .i_rqa      (i_rqa),
    .o_rqa_rd   (o_rqa_rd),
    .o_mrq_vld  (o_mrq_vld),
    .o_mrq_addr (o_mrq_addr),
    .i_mrq_rdy  (i_mrq_rdy),
    .i_mrs_vld  (i_mrs_vld),
    .i_mrs_data (i_mrs_data),
    .i_mrs_err  (i_mrs_err),
    .o_mrs_rdy  (o_mrs_rdy),
    .o_rss      (o_rss),
    .o_rss_wr   (o_rss_wr),
    .i_rss_rdy  (i_rss_rdy),
    .o_rsd      (o_rsd),
    .o_rsd_wr   (o_rsd_wr),
    .i_rsd_rdy  (i_rsd_rdy),
    .o_idle     (o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_rqa_vld = (rq_head != rq_tail);
  assign i_rqa     = rq_mem[rq_head];

  // Request FIFO pop and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_rqa_rd) begin
      rq_head      <= rq_head + 1;
      last_pop_cyc <= cyc;
    end
  end

  // Mid-cycle capture of bus issues and FIFO writes
  always @(negedge clk) begin
    if (o_mrq_vld && i_mrq_rdy) begin
      iss_addr[iss_cnt] <= o_mrq_addr;
      iss_cnt           <= iss_cnt + 1;
    end
    if (o_rss_wr) begin
      rss_log[ws_cnt] <= o_rss;
      rss_cyc[ws_cnt] <= cyc;
      ws_cnt          <= ws_cnt + 1;
    end
    if (o_rsd_wr) begin
      rsd_log[wd_cnt] <= o_rsd;
      wd_cnt          <= wd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rq(input logic [6:0] id, input logic [36:0] addr);
    rq_mem[rq_tail] = {id, addr};
    rq_tail++;
  endtask

  task automatic wait_iss(input int target);
    int n = 0;
    while (iss_cnt < target && n < 50) begin
      step();
      n++;
    end
    if (iss_cnt < target) chk("iss_wait", 64'(iss_cnt), 64'(target));
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (ws_cnt < target && n < 50) begin
      step();
      n++;
    end
    if (ws_cnt < target) chk("wr_wait", 64'(ws_cnt), 64'(target));
  endtask

  // Present one bus reply and hold it until accepted
  task automatic respond(input logic [63:0] d, input logic [1:0] e);
    int n = 0;
    i_mrs_vld  = 1'b1;
    i_mrs_data = d;
    i_mrs_err  = e;
    #1;
    while (!o_mrs_rdy && n < 50) begin
      step();
      n++;
    end
    if (!o_mrs_rdy) chk("resp_rdy", 64'(o_mrs_rdy), 64'd1);
    step();
    i_mrs_vld  = 1'b0;
    i_mrs_data = '0;
    i_mrs_err  = '0;
  endtask

  // Global time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ib;
    int wb;
    rst        = 1'b1;
    i_mrq_rdy  = 1'b0;
    i_mrs_vld  = 1'b0;
    i_mrs_data = '0;
    i_mrs_err  = '0;
    i_rss_rdy  = 1'b1;
    i_rsd_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_mrq_vld",  64'(o_mrq_vld),  64'd0);
    chk("rst_mrq_addr", 64'(o_mrq_addr), 64'd0);
    chk("rst_rss_wr",   64'(o_rss_wr),   64'd0);
    chk("rst_rsd_wr",   64'(o_rsd_wr),   64'd0);
    chk("rst_idle",     64'(o_idle),     64'd1);
    chk("rst_mrs_rdy",  64'(o_mrs_rdy),  64'd0);
    rst       = 1'b0;
    i_mrq_rdy = 1'b1;
    step();

    // Single request
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h05, 37'h100);
    #1;
    chk("t1_rqa_rd", 64'(o_rqa_rd), 64'd1);
    wait_iss(ib + 1);
    chk("t1_addr", 64'(iss_addr[ib]), 64'h800);
    chk("t1_busy", 64'(o_idle), 64'd0);
    respond(64'hA5, 2'b00);
    chk("t1_rss", 64'(rss_log[wb]), 64'h005);
    chk("t1_rsd", rsd_log[wb], 64'hA5);
    step();
    chk("t1_idle", 64'(o_idle), 64'd1);

    // Throughput: only MAX_OUT issued while the bus holds replies
    ib = iss_cnt; wb = ws_cnt;
    for (int i = 0; i < 6; i++) push_rq(7'(8'h10 + i), 37'(12'h200 + i));
    repeat (5) step();
    chk("t2_issued", 64'(iss_cnt - ib), 64'd4);
    chk("t2_rqa_rd", 64'(o_rqa_rd), 64'd0);
    chk("t2_mrq_vld", 64'(o_mrq_vld), 64'd0);
    for (int i = 0; i < 6; i++) respond(64'(16'hD0 + i), 2'b00);
    chk("t2_count", 64'(ws_cnt - wb), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("t2_rss", 64'(rss_log[wb + i]), 64'(9'h010 + i));
      chk("t2_rsd", rsd_log[wb + i], 64'(16'hD0 + i));
    end
    chk("t2_addr5", 64'(iss_addr[ib + 5]), 64'(40'h1028));

    // Error passthrough
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h03, 37'h55);
    wait_iss(ib + 1);
    respond(64'h1234_5678_9ABC_DEF0, 2'b10);
    chk("t3_rss", 64'(rss_log[wb]), 64'h103);
    chk("t3_rsd", rsd_log[wb], 64'h1234_5678_9ABC_DEF0);

    // Timeout then late reply discarded
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h21, 37'h7);
    wait_iss(ib + 1);
    wait_wr(wb + 1);
    chk("t4_rss", 64'(rss_log[wb]), 64'h1A1);
    chk("t4_rsd", rsd_log[wb], 64'h0);
    chk("t4_cycle", 64'(rss_cyc[wb]), 64'(last_pop_cyc + 9));
    chk("t4_busy", 64'(o_idle), 64'd0);
    respond(64'hDEAD, 2'b00);
    step();
    chk("t4_drop_nowr", 64'(ws_cnt - wb), 64'd1);
    chk("t4_idle", 64'(o_idle), 64'd1);
    ib = iss_cnt;
    push_rq(7'h22, 37'h2);
    wait_iss(ib + 1);
    respond(64'h77, 2'b01);
    chk("t4_next_rss", 64'(rss_log[wb + 1]), 64'h0A2);
    chk("t4_next_rsd", rsd_log[wb + 1], 64'h77);

    // Backpressure on the data FIFO
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h30, 37'h30);
    wait_iss(ib + 1);
    i_rsd_rdy  = 1'b0;
    i_mrs_vld  = 1'b1;
    i_mrs_data = 64'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_mrs_rdy", 64'(o_mrs_rdy), 64'd0);
      chk("t5_no_wr", 64'(o_rss_wr), 64'd0);
      step();
    end
    i_rsd_rdy = 1'b1;
    step();
    i_mrs_vld  = 1'b0;
    i_mrs_data = '0;
    chk("t5_count", 64'(ws_cnt - wb), 64'd1);
    chk("t5_rss", 64'(rss_log[wb]), 64'h030);
    chk("t5_rsd", rsd_log[wb], 64'hBEEF);

    // Reply and saturated timeout in the same cycle: reply wins
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h31, 37'h31);
    wait_iss(ib + 1);
    i_rsd_rdy = 1'b0;
    repeat (12) step();
    chk("t5b_held", 64'(ws_cnt - wb), 64'd0);
    i_rsd_rdy = 1'b1;
    respond(64'h31AA, 2'b00);
    chk("t5b_rss", 64'(rss_log[wb]), 64'h031);
    chk("t5b_rsd", rsd_log[wb], 64'h31AA);
    step();
    chk("t5b_idle", 64'(o_idle), 64'd1);

    // Blocked timeout fires exactly once when the FIFO frees
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h32, 37'h32);
    wait_iss(ib + 1);
    i_rsd_rdy = 1'b0;
    repeat (12) step();
    chk("t5c_held", 64'(ws_cnt - wb), 64'd0);
    i_rsd_rdy = 1'b1;
    repeat (10) step();
    chk("t5c_once", 64'(ws_cnt - wb), 64'd1);
    chk("t5c_rss", 64'(rss_log[wb]), 64'h1B2);
    chk("t5c_rsd", rsd_log[wb], 64'h0);
    respond(64'h99, 2'b00);
    step();
    chk("t5c_drop_nowr", 64'(ws_cnt - wb), 64'd1);
    chk("t5c_idle", 64'(o_idle), 64'd1);

    // Reset with three transactions owed
    ib = iss_cnt;
    push_rq(7'h40, 37'h40);
    push_rq(7'h41, 37'h41);
    push_rq(7'h42, 37'h42);
    wait_iss(ib + 3);
    chk("t6_busy", 64'(o_idle), 64'd0);
    rst = 1'b1;
    step();
    chk("t6_mrq_vld",  64'(o_mrq_vld),  64'd0);
    chk("t6_mrq_addr", 64'(o_mrq_addr), 64'd0);
    chk("t6_rss_wr",   64'(o_rss_wr),   64'd0);
    chk("t6_rsd_wr",   64'(o_rsd_wr),   64'd0);
    chk("t6_mrs_rdy",  64'(o_mrs_rdy),  64'd0);
    chk("t6_idle",     64'(o_idle),     64'd1);
    rst = 1'b0;
    step();
    ib = iss_cnt; wb = ws_cnt;
    push_rq(7'h44, 37'h1);
    wait_iss(ib + 1);
    chk("t6_addr", 64'(iss_addr[ib]), 64'h8);
    respond(64'h4444, 2'b00);
    chk("t6_rss", 64'(rss_log[wb]), 64'h044);
    chk("t6_rsd", rsd_log[wb], 64'h4444);

    // Both response FIFOs saw the same number of writes
    chk("total_rss_wr", 64'(ws_cnt), 64'd14);
    chk("total_rsd_wr", 64'(wd_cnt), 64'd14);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
